dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares the single-port word-addressed data memory (combinational read, word write on clock negedge) between two requesters: port 0 (CPU load/store) and port 1 (DMA/debug loader).
- Provides byte-enable stores. A partial store is sequenced as a read-modify-write, because the memory only accepts whole-word writes.
- Sits between the requesters and the data memory. It owns the memory's write-enable, address and write-data inputs.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration between ports; 0 = fixed priority, port 0 always wins.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- m0_req  input  1  port 0 request; held with fields stable until m0_ack
- m0_we  input  1  port 0: 1 = store, 0 = load
- m0_be  input  4  port 0 byte enables; bit i = byte i (bits 8i+7:8i); ignored for loads
- m0_addr  input  32  port 0 byte address; bits 1:0 ignored
- m0_wdata  input  32  port 0 store data, byte lanes aligned to the word
- m0_ack  output  1  one-cycle completion pulse for port 0
- m0_rdata  output  32  load data; valid while m0_ack is high
- m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_ack, m1_rdata: same as port 0, for port 1
- dm_wr  output  1  memory write enable
- dm_addr  output  32  memory byte address, always {addr[31:2],2'b00}
- dm_din  output  32  memory write data
- dm_dout  input  32  memory read data (combinational from dm_addr)

Behaviour:
- State machine states: IDLE, READ, WRITE, RESP.
- Grant is decided only in IDLE, at the rising edge.
  - RR_EN=1: with one request pending, that port wins. With both pending, the port not granted last wins. last_grant resets to 1, so port 0 wins the first tie.
  - RR_EN=0: port 0 wins any tie.
  - On grant, latch port id, we, be, addr and wdata.
- Transitions out of IDLE:
  - Load: IDLE -> READ -> RESP.
  - Store with be = 4'hF: IDLE -> WRITE -> RESP.
  - Store with be in 4'h1..4'hE: IDLE -> READ -> WRITE -> RESP.
  - Store with be = 4'h0: IDLE -> RESP. No memory access occurs.
- READ: dm_addr = latched word address. At the end of the cycle, capture dm_dout into the data register.
- WRITE: dm_wr = 1, dm_addr = latched address.
  - dm_din byte i = latched wdata byte i if be[i] is set, otherwise the captured byte i.
  - Full-word writes use wdata directly.
- RESP: the granted port's ack = 1 for exactly one cycle. That port's rdata = captured word; it is valid for loads only. Next state is always IDLE.
- Latency counts cycles after the IDLE cycle in which req is sampled; ack is asserted in:
  - load: cycle 2
  - full store: cycle 2
  - partial store: cycle 3
  - be = 0 store: cycle 1
- Handshake: a requester must drop req, or present a new request, during the cycle after its ack; req seen in IDLE is always treated as new. The ungranted port keeps req high and waits; no starvation under RR_EN=1.
- dm_wr is high only in WRITE, and is gated with !rst combinationally so a reset cycle never writes memory.
- dm_addr holds the last latched address outside active states (0 after reset). dm_din = 0 outside WRITE.
- Reset values: state = IDLE, m0_ack = m1_ack = 0, m0_rdata = m1_rdata = 0, dm_wr = 0, dm_addr = 0, dm_din = 0, last_grant = 1.
- Reset mid-operation: returns to IDLE at the edge. The transaction is dropped, no ack is issued and no partial write occurs; requesters must re-issue.
- Both acks are never high in the same cycle.

Test Plan:
- Reset, then m0 store addr 0x10, be = F, wdata 0xDEADBEEF -> one dm_wr cycle at dm_addr 0x10; m0_ack in cycle 2. Then m0 load 0x10 -> m0_rdata = 0xDEADBEEF with ack in cycle 2.
- Memory word 0x20 = 0x11223344; m1 store be = 4'b0101, wdata 0xAABBCCDD -> READ then WRITE; dm_din = 0x11BB33DD; m1_ack in cycle 3; a subsequent load returns 0x11BB33DD.
- m0 and m1 both request continuously with loads, RR_EN = 1 -> grants alternate 0,1,0,1; no back-to-back acks for one port while the other waits. With RR_EN = 0 -> port 0 is always granted.
- Store with be = 0 -> no dm_wr cycle; ack in cycle 1; memory unchanged.
- rst asserted during the WRITE cycle of a partial store to 0x30 -> dm_wr stays 0, no ack, memory word 0x30 unchanged, state IDLE.
- Unaligned address 0x13 with load -> dm_addr = 0x10; returns the full word.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-port arbiter for a single-port word-addressed data memory.
// Partial (byte-enable) stores are sequenced as read-modify-write.
module dm_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,

    output logic        dm_wr,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t      state;
    logic        port_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [29:0] waddr_q;
    logic [31:0] wdata_q;
    logic [31:0] data_q;
    logic        last_grant;

    logic        grant_valid;
    logic        grant_port;
    logic        g_we;
    logic [3:0]  g_be;
    logic [29:0] g_waddr;
    logic [31:0] g_wdata;
    logic [31:0] merged;

    // Byte offsets never reach the memory; the word address is all that is kept.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};

    always_comb begin
        grant_valid = m0_req | m1_req;
        if (m0_req && m1_req)
            grant_port = (RR_EN != 0) ? ~last_grant : 1'b0;
        else
            grant_port = m1_req;
        g_we    = grant_port ? m1_we            : m0_we;
        g_be    = grant_port ? m1_be            : m0_be;
        g_waddr = grant_port ? m1_addr[31:2]    : m0_addr[31:2];
        g_wdata = grant_port ? m1_wdata         : m0_wdata;
    end

    always_comb begin
        merged = '0;
        for (int unsigned i = 0; i < 4; i++)
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : data_q[8*i +: 8];
    end

    assign dm_addr = {waddr_q, 2'b00};
    assign dm_wr   = (state == WRITE) && !rst;
    assign dm_din  = (state == WRITE) ? merged : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            last_grant <= 1'b1;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        port_q     <= grant_port;
                        we_q       <= g_we;
                        be_q       <= g_be;
                        waddr_q    <= g_waddr;
                        wdata_q    <= g_wdata;
                        last_grant <= grant_port;
                        if (!g_we)
                            state <= READ;
                        else if (g_be == 4'hF)
                            state <= WRITE;
                        else if (g_be == 4'h0) begin
                            state <= RESP;
                            if (grant_port) m1_ack <= 1'b1;
                            else            m0_ack <= 1'b1;
                        end else
                            state <= READ;
                    end
                end
                READ: begin
                    data_q <= dm_dout;
                    if (we_q)
                        state <= WRITE;
                    else begin
                        state <= RESP;
                        if (port_q) begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= dm_dout;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_rdata <= dm_dout;
                        end
                    end
                end
                WRITE: begin
                    state <= RESP;
                    if (port_q) m1_ack <= 1'b1;
                    else        m0_ack <= 1'b1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: round-robin and fixed-priority instances, each with its
// own memory, checked against a word-level reference memory and latency rules.
module tb_dm_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        req0, req1, we0, we1;
    logic [3:0]  be0, be1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        mem_init;

    logic        rr_ack0, rr_ack1, rr_wr, fp_ack0, fp_ack1, fp_wr;
    logic [31:0] rr_rdata0, rr_rdata1, rr_addr, rr_din, rr_dout;
    logic [31:0] fp_rdata0, fp_rdata1, fp_addr, fp_din, fp_dout;

    logic [31:0] mem_rr [256];
    logic [31:0] mem_fp [256];
    logic [31:0] ref_mem [256];

    int checks = 0;
    int errors = 0;

    dm_arbiter #(.RR_EN(1)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_req(req0 & ~sel), .m0_we(we0), .m0_be(be0), .m0_addr(addr0), .m0_wdata(wdata0),
        .m0_ack(rr_ack0), .m0_rdata(rr_rdata0),
        .m1_req(req1 & ~sel), .m1_we(we1), .m1_be(be1), .m1_addr(addr1), .m1_wdata(wdata1),
        .m1_ack(rr_ack1), .m1_rdata(rr_rdata1),
        .dm_wr(rr_wr), .dm_addr(rr_addr), .dm_din(rr_din), .dm_dout(rr_dout)
    );

    dm_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(req0 & sel), .m0_we(we0), .m0_be(be0), .m0_addr(addr0), .m0_wdata(wdata0),
        .m0_ack(fp_ack0), .m0_rdata(fp_rdata0),
        .m1_req(req1 & sel), .m1_we(we1), .m1_be(be1), .m1_addr(addr1), .m1_wdata(wdata1),
        .m1_ack(fp_ack1), .m1_rdata(fp_rdata1),
        .dm_wr(fp_wr), .dm_addr(fp_addr), .dm_din(fp_din), .dm_dout(fp_dout)
    );

    assign rr_dout = mem_rr[rr_addr[9:2]];
    assign fp_dout = mem_fp[fp_addr[9:2]];

    logic        ack0_o, ack1_o, wr_o;
    logic [31:0] rdata0_o, rdata1_o, dmaddr_o, din_o;
    assign ack0_o   = sel ? fp_ack0   : rr_ack0;
    assign ack1_o   = sel ? fp_ack1   : rr_ack1;
    assign wr_o     = sel ? fp_wr     : rr_wr;
    assign rdata0_o = sel ? fp_rdata0 : rr_rdata0;
    assign rdata1_o = sel ? fp_rdata1 : rr_rdata1;
    assign dmaddr_o = sel ? fp_addr   : rr_addr;
    assign din_o    = sel ? fp_din    : rr_din;

    function automatic logic [31:0] init_word(int unsigned i);
        return (i == 8) ? 32'h11223344 : ((i * 32'h9E3779B1) ^ 32'h0F0F1234);
    endfunction

    // Memory behaves like the real data memory: word write on the falling edge.
    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem_rr[i] <= init_word(i);
                mem_fp[i] <= init_word(i);
            end
        end else begin
            if (rr_wr) mem_rr[rr_addr[9:2]] <= rr_din;
            if (fp_wr) mem_fp[fp_addr[9:2]] <= fp_din;
        end
    end

    function automatic int exp_lat(logic w, logic [3:0] b);
        if (!w)           return 2;
        if (b == 4'h0)    return 1;
        if (b == 4'hF)    return 2;
        return 3;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Drives one request on one port and records what the DUT did until its ack.
    task automatic run_txn(input bit p, input logic w, input logic [3:0] b,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd, output int nwr,
                           output logic [31:0] wdin, output logic [31:0] waddr,
                           output logic [31:0] addr_c1, output bit stray);
        @(posedge clk); #1;
        if (p) begin req1 = 1'b1; we1 = w; be1 = b; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; be0 = b; addr0 = a; wdata0 = d; end
        lat = 0; rd = '0; nwr = 0; wdin = '0; waddr = '0; addr_c1 = '0; stray = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) addr_c1 = dmaddr_o;
            if (wr_o) begin nwr++; wdin = din_o; waddr = dmaddr_o; end
            if (!wr_o && din_o !== 32'h0) stray = 1'b1;
            if (p ? ack0_o : ack1_o) stray = 1'b1;
            if (p ? ack1_o : ack0_o) begin
                lat = c;
                rd  = p ? rdata1_o : rdata0_o;
                break;
            end
        end
        if (p) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; be0 = 0; be1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        rst = 1'b1; mem_init = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        checks++;
        if ({rr_ack0, rr_ack1, rr_wr, fp_ack0, fp_ack1, fp_wr} !== 6'b0) begin
            errors++; $display("FAIL reset_ack_wr got %b exp 000000", {rr_ack0, rr_ack1, rr_wr, fp_ack0, fp_ack1, fp_wr});
        end
        checks++;
        if ({rr_rdata0, rr_rdata1} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata got %h %h exp 0", rr_rdata0, rr_rdata1);
        end
        checks++;
        if ({rr_addr, rr_din, fp_addr, fp_din} !== 128'h0) begin
            errors++; $display("FAIL reset_addr_din got %h %h exp 0", rr_addr, rr_din);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_full_store_load();
        int lat, nwr; logic [31:0] rd, wdin, waddr, a1; bit stray;
        run_txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, nwr, wdin, waddr, a1, stray);
        ref_mem[4] = 32'hDEADBEEF;
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL full_store_lat got %0d exp 2", lat); end
        checks++;
        if (nwr !== 1 || waddr !== 32'h10 || wdin !== 32'hDEADBEEF) begin
            errors++; $display("FAIL full_store_wr got n=%0d a=%h d=%h exp n=1 a=00000010 d=deadbeef", nwr, waddr, wdin);
        end
        run_txn(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, nwr, wdin, waddr, a1, stray);
        checks++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || nwr !== 0) begin
            errors++; $display("FAIL full_load got lat=%0d rd=%h nwr=%0d exp 2 deadbeef 0", lat, rd, nwr);
        end
    endtask

    task automatic test_partial_store();
        int lat, nwr; logic [31:0] rd, wdin, waddr, a1, expw; bit stray;
        expw = merge(ref_mem[8], 32'hAABBCCDD, 4'b0101);
        run_txn(1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, lat, rd, nwr, wdin, waddr, a1, stray);
        ref_mem[8] = expw;
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL partial_lat got %0d exp 3", lat); end
        checks++;
        if (nwr !== 1 || wdin !== 32'h11BB33DD || waddr !== 32'h20) begin
            errors++; $display("FAIL partial_din got n=%0d d=%h a=%h exp 1 11bb33dd 00000020", nwr, wdin, waddr);
        end
        run_txn(1, 1'b0, 4'h0, 32'h20, 32'h0, lat, rd, nwr, wdin, waddr, a1, stray);
        checks++;
        if (lat !== 2 || rd !== 32'h11BB33DD) begin
            errors++; $display("FAIL partial_readback got lat=%0d rd=%h exp 2 11bb33dd", lat, rd);
        end
    endtask

    task automatic test_be_zero();
        int lat, nwr; logic [31:0] rd, wdin, waddr, a1; bit stray;
        run_txn(0, 1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, lat, rd, nwr, wdin, waddr, a1, stray);
        checks++;
        if (lat !== 1 || nwr !== 0) begin
            errors++; $display("FAIL be0_store got lat=%0d nwr=%0d exp 1 0", lat, nwr);
        end
        run_txn(0, 1'b0, 4'h0, 32'h40, 32'h0, lat, rd, nwr, wdin, waddr, a1, stray);
        checks++;
        if (rd !== ref_mem[16]) begin errors++; $display("FAIL be0_unchanged got %h exp %h", rd, ref_mem[16]); end
    endtask

    task automatic test_unaligned();
        int lat, nwr; logic [31:0] rd, wdin, waddr, a1; bit stray;
        run_txn(0, 1'b0, 4'hF, 32'h13, 32'h0, lat, rd, nwr, wdin, waddr, a1, stray);
        checks++;
        if (a1 !== 32'h10) begin errors++; $display("FAIL unaligned_addr got %h exp 00000010", a1); end
        checks++;
        if (rd !== ref_mem[4] || lat !== 2) begin
            errors++; $display("FAIL unaligned_data got %h lat=%0d exp %h 2", rd, lat, ref_mem[4]);
        end
    endtask

    task automatic test_random();
        int lat, nwr; logic [31:0] rd, wdin, waddr, a1, a, d, expw; bit stray;
        bit p; logic w; logic [3:0] b; int idx;
        for (int n = 0; n < 24; n++) begin
            p = 1'($urandom_range(1)); w = 1'($urandom_range(1)); b = 4'($urandom);
            a = $urandom_range(1023); d = $urandom; idx = int'(a[9:2]);
            expw = merge(ref_mem[idx], d, b);
            run_txn(p, w, b, a, d, lat, rd, nwr, wdin, waddr, a1, stray);
            checks++;
            if (lat !== exp_lat(w, b) || stray) begin
                errors++; $display("FAIL rand_lat[%0d] got %0d stray=%0d exp %0d", n, lat, stray, exp_lat(w, b));
            end
            if (!w) begin
                checks++;
                if (rd !== ref_mem[idx] || nwr !== 0) begin
                    errors++; $display("FAIL rand_load[%0d] got %h nwr=%0d exp %h", n, rd, nwr, ref_mem[idx]);
                end
            end else if (b != 4'h0) begin
                checks++;
                if (nwr !== 1 || wdin !== expw || waddr !== {a[31:2], 2'b00}) begin
                    errors++; $display("FAIL rand_store[%0d] got n=%0d d=%h exp 1 %h", n, nwr, wdin, expw);
                end
                ref_mem[idx] = expw;
            end else begin
                checks++;
                if (nwr !== 0) begin errors++; $display("FAIL rand_be0[%0d] got nwr=%0d exp 0", n, nwr); end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int lat, nwr; logic [31:0] rd, wdin, waddr, a1; bit stray; bit saw_ack;
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; be0 = 4'h3; addr0 = 32'h30; wdata0 = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (rr_wr !== 1'b1) begin errors++; $display("FAIL midrst_pre_wr got %b exp 1", rr_wr); end
        rst = 1'b1; #1;
        checks++;
        if (rr_wr !== 1'b0) begin errors++; $display("FAIL midrst_wr_gated got %b exp 0", rr_wr); end
        saw_ack = rr_ack0 | rr_ack1;
        @(posedge clk); #1; rst = 1'b0; req0 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            saw_ack |= rr_ack0 | rr_ack1;
            @(posedge clk); #1;
        end
        checks++;
        if (saw_ack) begin errors++; $display("FAIL midrst_ack got 1 exp 0"); end
        checks++;
        if (mem_rr[12] !== ref_mem[12]) begin errors++; $display("FAIL midrst_mem got %h exp %h", mem_rr[12], ref_mem[12]); end
        run_txn(0, 1'b0, 4'h0, 32'h30, 32'h0, lat, rd, nwr, wdin, waddr, a1, stray);
        checks++;
        if (lat !== 2 || rd !== ref_mem[12]) begin
            errors++; $display("FAIL midrst_idle got lat=%0d rd=%h exp 2 %h", lat, rd, ref_mem[12]);
        end
    endtask

    // Both ports load continuously; the expected winner follows the tie rule.
    task automatic test_contention(input bit fixed);
        int grants, cyc, n1; bit prev, expg, both; logic [31:0] exp0, exp1;
        sel = fixed;
        pulse_reset();
        we0 = 1'b0; we1 = 1'b0; be0 = 4'h0; be1 = 4'h0;
        addr0 = $urandom_range(1023); addr1 = $urandom_range(1023);
        req0 = 1'b1; req1 = 1'b1;
        prev = 1'b1; grants = 0; cyc = 0; both = 1'b0; n1 = 0;
        while (grants < 8 && cyc < 80) begin
            @(posedge clk); #1; cyc++;
            exp0 = fixed ? init_word(addr0[9:2]) : ref_mem[addr0[9:2]];
            exp1 = fixed ? init_word(addr1[9:2]) : ref_mem[addr1[9:2]];
            if (ack0_o && ack1_o) both = 1'b1;
            if (ack0_o || ack1_o) begin
                expg = fixed ? 1'b0 : ~prev;
                prev = ack1_o;
                if (ack1_o) n1++;
                checks++;
                if (ack1_o !== expg) begin
                    errors++; $display("FAIL grant_%s[%0d] got %0d exp %0d", fixed ? "fp" : "rr", grants, ack1_o, expg);
                end
                checks++;
                if ((ack1_o ? rdata1_o : rdata0_o) !== (ack1_o ? exp1 : exp0)) begin
                    errors++; $display("FAIL grant_data[%0d] got %h exp %h", grants, ack1_o ? rdata1_o : rdata0_o, ack1_o ? exp1 : exp0);
                end
                if (ack1_o) addr1 = $urandom_range(1023); else addr0 = $urandom_range(1023);
                grants++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (grants !== 8 || both) begin
            errors++; $display("FAIL contention_%s got grants=%0d both=%0d exp 8 0", fixed ? "fp" : "rr", grants, both);
        end
        checks++;
        if (n1 !== (fixed ? 0 : 4)) begin
            errors++; $display("FAIL port1_share got %0d exp %0d", n1, fixed ? 0 : 4);
        end
        repeat (3) @(posedge clk);
        #1 sel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_store_load();
        test_partial_store();
        test_be_zero();
        test_unaligned();
        test_random();
        test_reset_mid_write();
        test_contention(1'b0);
        test_contention(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
